// File: rtl/nvme_admin_queue_fifo.sv
// Single-clock admin-path FIFO with occupancy, almost-full, show-ahead read
// and sticky overflow/underflow flags. Flags are registered from next occupancy.
module nvme_admin_queue_fifo #(
  parameter int unsigned WIDTH     = 181,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned SHOWAHEAD = 0,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdempty,
  output logic             wrfull,
  output logic             almost_full,
  output logic [AW:0]      usedw,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW-1:0]    wp_nxt;
  logic [AW-1:0]    rp_nxt;
  logic [AW:0]      usedw_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // Accept decisions use only registered flags, so no request-to-flag path exists.
  always_comb begin
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    wp_nxt    = wp;
    rp_nxt    = rp;
    usedw_nxt = usedw;
    q_nxt     = q;

    wr_acc    = wrreq & ~wrfull;
    rd_acc    = rdreq & ~rdempty;
    if (wr_acc) wp_nxt = wp + AW'(1);
    if (rd_acc) rp_nxt = rp + AW'(1);
    usedw_nxt = usedw + CW'(wr_acc) - CW'(rd_acc);

    if (SHOWAHEAD != 0) begin
      // Next head may be the entry being written this cycle (FIFO becoming non-empty).
      if (usedw_nxt == CW'(0))
        q_nxt = '0;
      else if (wr_acc && (rp_nxt == wp))
        q_nxt = data;
      else
        q_nxt = mem[rp_nxt];
    end else begin
      if (rd_acc) q_nxt = mem[rp];
    end
  end

  // Pointers, occupancy, flags and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp            <= '0;
      rp            <= '0;
      usedw         <= '0;
      rdempty       <= 1'b1;
      wrfull        <= 1'b0;
      almost_full   <= 1'b0;
      q             <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      wp          <= wp_nxt;
      rp          <= rp_nxt;
      usedw       <= usedw_nxt;
      rdempty     <= (usedw_nxt == CW'(0));
      wrfull      <= (usedw_nxt == CW'(DEPTH));
      almost_full <= (usedw_nxt >= CW'(AF_THRESH));
      q           <= q_nxt;
      if (wrreq && wrfull)  overflow_err  <= 1'b1;
      if (rdreq && rdempty) underflow_err <= 1'b1;
    end
  end

  // Storage is not reset; requests during reset never write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wp] <= data;
  end

endmodule

// File: tb/tb_nvme_admin_queue_fifo.sv
// Directed bench: a normal-mode and a show-ahead instance checked each cycle
// against a queue-based model, plus hand-computed literal checkpoints.
module tb_nvme_admin_queue_fifo;

  localparam int unsigned W   = 181;
  localparam int unsigned D   = 4;
  localparam int unsigned AF  = 2;
  localparam int unsigned AWB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d0, d1;
  logic          wr0, rd0, wr1, rd1;
  logic [W-1:0]  q0, q1;
  logic          emp0, full0, af0, ovf0, unf0;
  logic          emp1, full1, af1, ovf1, unf1;
  logic [AWB:0]  uw0, uw1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nvme_admin_queue_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .SHOWAHEAD(0)) u_norm (
    .clk(clk), .rst(rst), .data(d0), .wrreq(wr0), .rdreq(rd0), .q(q0),
    .rdempty(emp0), .wrfull(full0), .almost_full(af0), .usedw(uw0),
    .overflow_err(ovf0), .underflow_err(unf0));

  nvme_admin_queue_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .SHOWAHEAD(1)) u_sa (
    .clk(clk), .rst(rst), .data(d1), .wrreq(wr1), .rdreq(rd1), .q(q1),
    .rdempty(emp1), .wrfull(full1), .almost_full(af1), .usedw(uw1),
    .overflow_err(ovf1), .underflow_err(unf1));

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: queues of accepted entries, rules applied on each edge.
  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];
  logic [W-1:0] mqout0;
  logic         movf0, munf0, movf1, munf1;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq0.delete(); mq1.delete();
      mqout0 = '0;
      movf0 = 1'b0; munf0 = 1'b0; movf1 = 1'b0; munf1 = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (wr0 && mq0.size() == D) movf0 = 1'b1;
      if (rd0 && mq0.size() == 0) munf0 = 1'b1;
      if (wr1 && mq1.size() == D) movf1 = 1'b1;
      if (rd1 && mq1.size() == 0) munf1 = 1'b1;
      begin
        automatic bit wa0 = wr0 && (mq0.size() < D);
        automatic bit ra0 = rd0 && (mq0.size() > 0);
        automatic bit wa1 = wr1 && (mq1.size() < D);
        automatic bit ra1 = rd1 && (mq1.size() > 0);
        if (ra0) mqout0 = mq0.pop_front();
        if (wa0) mq0.push_back(d0);
        if (ra1) void'(mq1.pop_front());
        if (wa1) mq1.push_back(d1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("n_q",     q0,          mqout0);
      chk("n_usedw", W'(uw0),     W'(mq0.size()));
      chk("n_empty", W'(emp0),    W'(mq0.size() == 0));
      chk("n_full",  W'(full0),   W'(mq0.size() == D));
      chk("n_af",    W'(af0),     W'(mq0.size() >= AF));
      chk("n_ovf",   W'(ovf0),    W'(movf0));
      chk("n_unf",   W'(unf0),    W'(munf0));
      chk("s_q",     q1,          (mq1.size() > 0) ? mq1[0] : '0);
      chk("s_usedw", W'(uw1),     W'(mq1.size()));
      chk("s_empty", W'(emp1),    W'(mq1.size() == 0));
      chk("s_full",  W'(full1),   W'(mq1.size() == D));
      chk("s_af",    W'(af1),     W'(mq1.size() >= AF));
      chk("s_ovf",   W'(ovf1),    W'(movf1));
      chk("s_unf",   W'(unf1),    W'(munf1));
    end
  end

  task automatic step(input logic w0, input logic [W-1:0] dd0, input logic r0,
                      input logic w1, input logic [W-1:0] dd1, input logic r1);
    wr0 = w0; d0 = dd0; rd0 = r0;
    wr1 = w1; d1 = dd1; rd1 = r1;
    @(posedge clk);
    #1;
  endtask

  task automatic n_step(input logic w, input logic [W-1:0] dd, input logic r);
    step(w, dd, r, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    wr0 = 1'b0; rd0 = 1'b0; d0 = '0;
    wr1 = 1'b0; rd1 = 1'b0; d1 = '0;
    n_step(0, '0, 0);
    n_step(0, '0, 0);
    rst = 1'b0;
    n_step(0, '0, 0);
    chk("lit_rst_empty", W'(emp0), W'(1));
    chk("lit_rst_usedw", W'(uw0),  W'(0));
    chk("lit_rst_q",     q0,       W'(0));
    chk("lit_rst_errs",  W'({ovf0, unf0, full0}), W'(0));

    // Fill to full, then one rejected write.
    for (int i = 1; i <= 4; i++) begin
      n_step(1, W'(i), 0);
      chk("lit_fill_usedw", W'(uw0), W'(i));
      chk("lit_fill_af",    W'(af0), W'(i >= 2));
    end
    chk("lit_full", W'(full0), W'(1));
    n_step(1, W'(5), 0);
    chk("lit_ovf_usedw", W'(uw0),  W'(4));
    chk("lit_ovf",       W'(ovf0), W'(1));

    // Drain in order, then one rejected read.
    for (int i = 1; i <= 4; i++) begin
      n_step(0, '0, 1);
      chk("lit_drain_q", q0, W'(i));
    end
    chk("lit_drain_empty", W'(emp0), W'(1));
    n_step(0, '0, 1);
    chk("lit_unf",      W'(unf0), W'(1));
    chk("lit_unf_hold", q0,       W'(4));

    // Simultaneous requests at usedw 0, 2 and 4.
    n_step(1, W'('h31), 1);
    chk("lit_sim0", W'(uw0), W'(1));
    n_step(1, W'('h32), 0);
    n_step(1, W'('h33), 1);
    chk("lit_sim2", W'(uw0), W'(2));
    n_step(1, W'('h34), 0);
    n_step(1, W'('h35), 0);
    n_step(1, W'('h36), 1);
    chk("lit_sim4", W'(uw0), W'(3));
    for (int i = 0; i < 3; i++) n_step(0, '0, 1);
    chk("lit_sim_drained", W'(emp0), W'(1));

    // Streaming across pointer wrap.
    for (int i = 0; i < 20; i++) n_step(1, W'('h10 + i), 1);
    chk("lit_stream_q", q0, W'('h22));
    n_step(0, '0, 1);
    chk("lit_stream_last", q0, W'('h23));

    // Show-ahead instance.
    step(0, '0, 0, 1, W'('hA), 0);
    chk("lit_sa_head", q1, W'('hA));
    step(0, '0, 0, 1, W'('hB), 0);
    chk("lit_sa_hold", q1, W'('hA));
    step(0, '0, 0, 0, '0, 1);
    chk("lit_sa_pop1", q1, W'('hB));
    step(0, '0, 0, 0, '0, 1);
    chk("lit_sa_pop2", q1, W'(0));
    chk("lit_sa_empty", W'(emp1), W'(1));

    // Reset with three stored entries and both requests active.
    n_step(1, W'('h41), 0);
    n_step(1, W'('h42), 0);
    n_step(1, W'('h43), 0);
    chk("lit_pre_rst_usedw", W'(uw0), W'(3));
    rst = 1'b1;
    n_step(1, W'('h44), 1);
    rst = 1'b0;
    chk("lit_rst2_usedw", W'(uw0),  W'(0));
    chk("lit_rst2_empty", W'(emp0), W'(1));
    chk("lit_rst2_errs",  W'({ovf0, unf0}), W'(0));
    n_step(0, '0, 0);
    n_step(0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
